// File: rtl/regfile_access_ctrl.sv
// Purpose: initiator-side controller for the 8x8 register file; serialises read-pair
//   and write requests onto the regfile ports and returns read data on a response channel.
// Latency: write commits one edge after accept (wr_done pulses then); read response
//   is valid READ_LAT edges after accept.
// Backpressure: req_ready is low whenever busy; a response is held until rsp_ready.
//
// Optional feature macro: RF_ZERO_REG_EN (register 0 reads as zero, writes to it
//   are dropped at the regfile but still complete normally).
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   req_*              request channel (valid/ready), write flag, addresses, write data
//   rsp_*              read response channel (valid/ready), two data words
//   wr_done, wr_count  one-cycle write-commit pulse and modulo-256 commit counter
//   r_addr1/r_addr2    regfile read addresses; data1/data2 come back from the regfile
//   w_addr/w_data      regfile write address/data; r_or_w = 1 writes on the next edge
//
// All outputs are registered.

module regfile_access_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              wr_done,
  output logic [7:0]        wr_count,
  output logic [ADDR_W-1:0] r_addr1,
  output logic [ADDR_W-1:0] r_addr2,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              r_or_w,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2
);

  // Legal read latency is 1..4; anything outside is clamped into that range.
  localparam int unsigned LAT   = (READ_LAT < 1) ? 1 : ((READ_LAT > 4) ? 4 : READ_LAT);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_READ_WAIT = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data1;
  logic [DATA_W-1:0] r_rsp_data2;
  logic              r_wr_done;
  logic [7:0]        r_wr_count;
  logic [ADDR_W-1:0] r_raddr1;
  logic [ADDR_W-1:0] r_raddr2;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr_en;

  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_req_ready_nxt;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] w_rsp_data1_nxt;
  logic [DATA_W-1:0] w_rsp_data2_nxt;
  logic              w_wr_done_nxt;
  logic [7:0]        w_wr_count_nxt;
  logic [ADDR_W-1:0] w_raddr1_nxt;
  logic [ADDR_W-1:0] w_raddr2_nxt;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_wr_en_nxt;

  logic w_accept;
  logic w_zero_wr;
  logic w_zero_rd1;
  logic w_zero_rd2;

  // r_req_ready is only ever high in IDLE, so it alone qualifies the handshake.
  assign w_accept = req_valid & r_req_ready;

`ifdef RF_ZERO_REG_EN
  // Register 0 is hardwired to zero: suppress its write strobe and mask its read data.
  assign w_zero_wr  = (req_addr1 == '0);
  assign w_zero_rd1 = (r_raddr1 == '0);
  assign w_zero_rd2 = (r_raddr2 == '0);
`else
  assign w_zero_wr  = 1'b0;
  assign w_zero_rd1 = 1'b0;
  assign w_zero_rd2 = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = req_write ? S_WRITE : S_READ_WAIT;
        end
      end
      S_WRITE:     w_state_nxt = S_IDLE;
      S_READ_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data1_nxt = r_rsp_data1;
    w_rsp_data2_nxt = r_rsp_data2;
    w_wr_done_nxt   = 1'b0;
    w_wr_count_nxt  = r_wr_count;
    w_raddr1_nxt    = r_raddr1;
    w_raddr2_nxt    = r_raddr2;
    w_waddr_nxt     = r_waddr;
    w_wdata_nxt     = r_wdata;
    w_wr_en_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_write) begin
            w_waddr_nxt = req_addr1;
            w_wdata_nxt = req_wdata;
            w_wr_en_nxt = ~w_zero_wr;
          end else begin
            w_raddr1_nxt = req_addr1;
            w_raddr2_nxt = req_addr2;
            w_cnt_nxt    = CNT_W'(LAT);
          end
        end
      end
      S_WRITE: begin
        // The regfile commits on this edge; the count covers writes to a zero register too.
        w_wr_done_nxt  = 1'b1;
        w_wr_count_nxt = r_wr_count + 8'd1;
      end
      S_READ_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data1_nxt = w_zero_rd1 ? '0 : data1;
          w_rsp_data2_nxt = w_zero_rd2 ? '0 : data2;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data1 <= '0;
      r_rsp_data2 <= '0;
      r_wr_done   <= 1'b0;
      r_wr_count  <= '0;
      r_raddr1    <= '0;
      r_raddr2    <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_wr_en     <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data1 <= w_rsp_data1_nxt;
      r_rsp_data2 <= w_rsp_data2_nxt;
      r_wr_done   <= w_wr_done_nxt;
      r_wr_count  <= w_wr_count_nxt;
      r_raddr1    <= w_raddr1_nxt;
      r_raddr2    <= w_raddr2_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wr_en     <= w_wr_en_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data1 = r_rsp_data1;
  assign rsp_data2 = r_rsp_data2;
  assign wr_done   = r_wr_done;
  assign wr_count  = r_wr_count;
  assign r_addr1   = r_raddr1;
  assign r_addr2   = r_raddr2;
  assign w_addr    = r_waddr;
  assign w_data    = r_wdata;
  assign r_or_w    = r_wr_en;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: instance A uses READ_LAT=1, instance B
// uses READ_LAT=3. Each has an 8x8 regfile model with combinational read and a
// write on the rising edge while r_or_w is high; entry i starts at 8'h10+i.

module tb_regfile_access_ctrl;

`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rf_init;

  // Instance A signals
  logic       rst_a, req_valid_a, req_write_a, rsp_ready_a;
  logic [2:0] req_addr1_a, req_addr2_a;
  logic [7:0] req_wdata_a;
  logic       req_ready_a, rsp_valid_a, wr_done_a, r_or_w_a;
  logic [7:0] rsp_data1_a, rsp_data2_a, wr_count_a, wdata_a, data1_a, data2_a;
  logic [2:0] raddr1_a, raddr2_a, waddr_a;
  logic [7:0] mem_a [8];

  // Instance B signals
  logic       rst_b, req_valid_b, req_write_b, rsp_ready_b;
  logic [2:0] req_addr1_b, req_addr2_b;
  logic [7:0] req_wdata_b;
  logic       req_ready_b, rsp_valid_b, wr_done_b, r_or_w_b;
  logic [7:0] rsp_data1_b, rsp_data2_b, wr_count_b, wdata_b, data1_b, data2_b;
  logic [2:0] raddr1_b, raddr2_b, waddr_b;
  logic [7:0] mem_b [8];

  regfile_access_ctrl #(.ADDR_W(3), .DATA_W(8), .READ_LAT(1)) u_dut_a (
    .clk(clk), .reset(rst_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr1(req_addr1_a), .req_addr2(req_addr2_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_data1(rsp_data1_a), .rsp_data2(rsp_data2_a),
    .wr_done(wr_done_a), .wr_count(wr_count_a),
    .r_addr1(raddr1_a), .r_addr2(raddr2_a), .w_addr(waddr_a), .w_data(wdata_a),
    .r_or_w(r_or_w_a), .data1(data1_a), .data2(data2_a)
  );

  regfile_access_ctrl #(.ADDR_W(3), .DATA_W(8), .READ_LAT(3)) u_dut_b (
    .clk(clk), .reset(rst_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr1(req_addr1_b), .req_addr2(req_addr2_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_data1(rsp_data1_b), .rsp_data2(rsp_data2_b),
    .wr_done(wr_done_b), .wr_count(wr_count_b),
    .r_addr1(raddr1_b), .r_addr2(raddr2_b), .w_addr(waddr_b), .w_data(wdata_b),
    .r_or_w(r_or_w_b), .data1(data1_b), .data2(data2_b)
  );

  // Regfile models
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 8; i++) begin
        mem_a[i] <= 8'(16 + i);
        mem_b[i] <= 8'(16 + i);
      end
    end else begin
      if (r_or_w_a) mem_a[waddr_a] <= wdata_a;
      if (r_or_w_b) mem_b[waddr_b] <= wdata_b;
    end
  end

  assign data1_a = mem_a[raddr1_a];
  assign data2_a = mem_a[raddr2_a];
  assign data1_b = mem_b[raddr1_b];
  assign data2_b = mem_b[raddr2_b];

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write on A; starts and ends in IDLE with req_ready high.
  task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp_cnt);
    req_valid_a = 1'b1; req_write_a = 1'b1;
    req_addr1_a = a; req_addr2_a = ~a; req_wdata_a = d;
    tick();
    req_valid_a = 1'b0;
    chk("wr_req_ready_low", 32'(req_ready_a), 32'd0);
    chk("wr_r_or_w",        32'(r_or_w_a), (ZR && a == 3'd0) ? 32'd0 : 32'd1);
    chk("wr_w_addr",        32'(waddr_a), 32'(a));
    chk("wr_w_data",        32'(wdata_a), 32'(d));
    chk("wr_done_early",    32'(wr_done_a), 32'd0);
    tick();
    chk("wr_r_or_w_off",    32'(r_or_w_a), 32'd0);
    chk("wr_done",          32'(wr_done_a), 32'd1);
    chk("wr_count",         32'(wr_count_a), 32'(exp_cnt));
    chk("wr_req_ready_back",32'(req_ready_a), 32'd1);
    tick();
    chk("wr_done_pulse",    32'(wr_done_a), 32'd0);
  endtask

  // Read pair on A (READ_LAT=1), consumed immediately.
  task automatic do_read(input logic [2:0] a1, input logic [2:0] a2,
                         input logic [7:0] e1, input logic [7:0] e2);
    req_valid_a = 1'b1; req_write_a = 1'b0;
    req_addr1_a = a1; req_addr2_a = a2; req_wdata_a = 8'hA5;
    tick();
    req_valid_a = 1'b0;
    chk("rd_req_ready_low", 32'(req_ready_a), 32'd0);
    chk("rd_rsp_valid_early", 32'(rsp_valid_a), 32'd0);
    chk("rd_r_addr1",       32'(raddr1_a), 32'(a1));
    chk("rd_r_addr2",       32'(raddr2_a), 32'(a2));
    chk("rd_r_or_w",        32'(r_or_w_a), 32'd0);
    tick();
    chk("rd_rsp_valid",     32'(rsp_valid_a), 32'd1);
    chk("rd_rsp_data1",     32'(rsp_data1_a), 32'(e1));
    chk("rd_rsp_data2",     32'(rsp_data2_a), 32'(e2));
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
    chk("rd_rsp_valid_drop", 32'(rsp_valid_a), 32'd0);
    chk("rd_req_ready_back", 32'(req_ready_a), 32'd1);
    chk("rd_rsp_data1_hold", 32'(rsp_data1_a), 32'(e1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rf_init = 1'b1;
    rst_a = 1'b1; req_valid_a = 1'b0; req_write_a = 1'b0; rsp_ready_a = 1'b0;
    req_addr1_a = '0; req_addr2_a = '0; req_wdata_a = '0;
    rst_b = 1'b1; req_valid_b = 1'b0; req_write_b = 1'b0; rsp_ready_b = 1'b0;
    req_addr1_b = '0; req_addr2_b = '0; req_wdata_b = '0;

    // Reset held for two cycles
    tick();
    tick();
    rf_init = 1'b0;
    chk("rst_req_ready",  32'(req_ready_a), 32'd0);
    chk("rst_rsp_valid",  32'(rsp_valid_a), 32'd0);
    chk("rst_wr_done",    32'(wr_done_a), 32'd0);
    chk("rst_r_or_w",     32'(r_or_w_a), 32'd0);
    chk("rst_wr_count",   32'(wr_count_a), 32'd0);
    chk("rst_r_addr1",    32'(raddr1_a), 32'd0);
    chk("rst_w_addr",     32'(waddr_a), 32'd0);
    chk("rst_w_data",     32'(wdata_a), 32'd0);
    chk("rst_rsp_data1",  32'(rsp_data1_a), 32'd0);
    chk("rst_b_req_ready",32'(req_ready_b), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    chk("post_rst_req_ready",   32'(req_ready_a), 32'd1);
    chk("post_rst_b_req_ready", 32'(req_ready_b), 32'd1);

    // Write then read-after-write
    do_write(3'd2, 8'd63, 8'd1);
    do_read(3'd2, 3'd1, 8'd63, 8'h11);
    do_write(3'd4, 8'd31, 8'd2);
    do_read(3'd4, 3'd2, 8'd31, 8'd63);

    // Response stall: pending request must not be accepted while RESP is held
    req_valid_a = 1'b1; req_write_a = 1'b0; req_addr1_a = 3'd1; req_addr2_a = 3'd2;
    tick();
    req_write_a = 1'b1; req_addr1_a = 3'd7; req_wdata_a = 8'hEE;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", 32'(rsp_valid_a), 32'd1);
      chk("stall_rsp_data1", 32'(rsp_data1_a), 32'h11);
      chk("stall_rsp_data2", 32'(rsp_data2_a), 32'd63);
      chk("stall_req_ready", 32'(req_ready_a), 32'd0);
      chk("stall_r_or_w",    32'(r_or_w_a), 32'd0);
      tick();
    end
    req_valid_a = 1'b0;
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
    chk("stall_release_valid", 32'(rsp_valid_a), 32'd0);
    chk("stall_release_ready", 32'(req_ready_a), 32'd1);
    chk("stall_no_write",      32'(wr_count_a), 32'd2);

    // Register 0 handling
    do_write(3'd0, 8'd99, 8'd3);
    do_read(3'd0, 3'd2, ZR ? 8'd0 : 8'd99, 8'd63);
    do_read(3'd2, 3'd0, 8'd63, ZR ? 8'd0 : 8'd99);

    // Reset at the commit edge of a write: regfile still commits, counter does not
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr1_a = 3'd5; req_wdata_a = 8'h55;
    tick();
    req_valid_a = 1'b0;
    rst_a = 1'b1;
    tick();
    chk("rstwr_wr_done",   32'(wr_done_a), 32'd0);
    chk("rstwr_wr_count",  32'(wr_count_a), 32'd0);
    chk("rstwr_r_or_w",    32'(r_or_w_a), 32'd0);
    chk("rstwr_req_ready", 32'(req_ready_a), 32'd0);
    rst_a = 1'b0;
    tick();
    chk("rstwr_ready_back",  32'(req_ready_a), 32'd1);
    chk("rstwr_no_done",     32'(wr_done_a), 32'd0);
    do_read(3'd5, 3'd4, 8'h55, 8'd31);

    // Reset during READ_WAIT on A discards the response
    req_valid_a = 1'b1; req_write_a = 1'b0; req_addr1_a = 3'd2; req_addr2_a = 3'd4;
    tick();
    req_valid_a = 1'b0;
    rst_a = 1'b1;
    tick();
    chk("rstrd_rsp_valid", 32'(rsp_valid_a), 32'd0);
    rst_a = 1'b0;
    tick();
    chk("rstrd_rsp_valid2", 32'(rsp_valid_a), 32'd0);
    chk("rstrd_req_ready",  32'(req_ready_a), 32'd1);
    tick();
    chk("rstrd_rsp_valid3", 32'(rsp_valid_a), 32'd0);

    // 256 writes wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      do_write(3'd6, 8'(i), 8'(i + 1));
    end
    chk("wrap_wr_count", 32'(wr_count_a), 32'd0);
    do_read(3'd6, 3'd2, 8'hFF, 8'd63);

    // Instance B: READ_LAT=3, back-to-back reads with rsp_ready held high
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr1_b = 3'd3; req_addr2_b = 3'd5;
    rsp_ready_b = 1'b1;
    tick();
    chk("b1_req_ready_low", 32'(req_ready_b), 32'd0);
    chk("b1_lat0",          32'(rsp_valid_b), 32'd0);
    req_addr1_b = 3'd6; req_addr2_b = 3'd7;
    tick();
    chk("b1_lat1",          32'(rsp_valid_b), 32'd0);
    tick();
    chk("b1_lat2",          32'(rsp_valid_b), 32'd0);
    tick();
    chk("b1_lat3_valid",    32'(rsp_valid_b), 32'd1);
    chk("b1_data1",         32'(rsp_data1_b), 32'h13);
    chk("b1_data2",         32'(rsp_data2_b), 32'h15);
    tick();
    chk("b1_drop",          32'(rsp_valid_b), 32'd0);
    chk("b1_ready_back",    32'(req_ready_b), 32'd1);
    tick();
    chk("b2_req_ready_low", 32'(req_ready_b), 32'd0);
    req_valid_b = 1'b0;
    tick();
    chk("b2_lat1",          32'(rsp_valid_b), 32'd0);
    tick();
    chk("b2_lat2",          32'(rsp_valid_b), 32'd0);
    tick();
    chk("b2_lat3_valid",    32'(rsp_valid_b), 32'd1);
    chk("b2_data1",         32'(rsp_data1_b), 32'h16);
    chk("b2_data2",         32'(rsp_data2_b), 32'h17);
    tick();
    chk("b2_drop",          32'(rsp_valid_b), 32'd0);
    rsp_ready_b = 1'b0;

    // Instance B: reset in the middle of READ_WAIT
    req_valid_b = 1'b1; req_addr1_b = 3'd1; req_addr2_b = 3'd1;
    tick();
    req_valid_b = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("b_rst_rsp_valid", 32'(rsp_valid_b), 32'd0);
    chk("b_rst_req_ready", 32'(req_ready_b), 32'd0);
    tick();
    chk("b_rst_ready_back", 32'(req_ready_b), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("b_rst_no_rsp", 32'(rsp_valid_b), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
